// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: shared raster timing defaults, phase encoding and total-length helper
package lcd_timing_pkg;
  typedef enum logic [1:0] {PH_SYNC, PH_BP, PH_ACTIVE, PH_FP} phase_t;
  localparam int H_SYNC_DEF   = 4;
  localparam int H_BP_DEF     = 43;
  localparam int H_ACTIVE_DEF = 480;
  localparam int H_FP_DEF     = 8;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 12;
  localparam int V_ACTIVE_DEF = 272;
  localparam int V_FP_DEF     = 8;
  localparam int CW_DEF       = 10;
  function automatic int axis_total(input int s, input int bp, input int a, input int fp);
    return s + bp + a + fp;
  endfunction
endpackage

// File: rtl/lcd_axis_counter.sv
// lcd_axis_counter: one raster axis counter with phase decode and terminal-count wrap
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int SYNC   = 4,
  parameter int BP     = 43,
  parameter int ACTIVE = 480,
  parameter int FP     = 8,
  parameter int CW     = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          step_i,
  output logic [CW-1:0] cnt_o,
  output phase_t        phase_o,
  output logic          wrap_o
);
  localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);
  assign wrap_o = step_i && cnt_o == CW'(TOTAL - 1);
  always_ff @(posedge clk_i)
    if (rst_i) cnt_o <= '0;
    else if (step_i) cnt_o <= wrap_o ? '0 : cnt_o + 1'b1;
  always_comb
    phase_o = cnt_o < CW'(SYNC)               ? PH_SYNC :
              cnt_o < CW'(SYNC + BP)          ? PH_BP :
              cnt_o < CW'(SYNC + BP + ACTIVE) ? PH_ACTIVE : PH_FP;
endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD raster timing with one-ahead pixel fetch and registered RGB565 panel outputs
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          pix_req_o,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  input  logic [15:0]   pix_data_i,
  input  logic          pix_valid_i,
  output logic          frame_start_o,
  output logic          lcd_de_o,
  output logic          lcd_hsync_o,
  output logic          lcd_vsync_o,
  output logic [4:0]    lcd_r_o,
  output logic [5:0]    lcd_g_o,
  output logic [4:0]    lcd_b_o,
  output logic          underflow_o
);
  logic [CW-1:0] h_cnt, v_cnt;
  phase_t        h_ph, v_ph;
  logic          h_wrap, v_wrap;
  logic          fs_q, de1, hs1, vs1;
  logic [15:0]   rgb_q;
  lcd_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CW(CW)) u_h (
    .clk_i(clk_i), .rst_i(rst_i), .step_i(1'b1),
    .cnt_o(h_cnt), .phase_o(h_ph), .wrap_o(h_wrap)
  );
  lcd_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CW(CW)) u_v (
    .clk_i(clk_i), .rst_i(rst_i), .step_i(h_wrap),
    .cnt_o(v_cnt), .phase_o(v_ph), .wrap_o(v_wrap)
  );
  always_comb begin
    pix_req_o     = h_ph == PH_ACTIVE && v_ph == PH_ACTIVE && !rst_i;
    x_o           = pix_req_o ? h_cnt - CW'(H_SYNC + H_BP) : '0;
    y_o           = pix_req_o ? v_cnt - CW'(V_SYNC + V_BP) : '0;
    frame_start_o = fs_q && !rst_i;
  end
  // fs_q marks raster (0,0): preset by reset, then loaded at the last position of each frame
  always_ff @(posedge clk_i)
    if (rst_i) begin
      fs_q        <= 1'b1;
      de1         <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      lcd_de_o    <= 1'b0;
      rgb_q       <= '0;
      lcd_hsync_o <= ~SYNC_POL;
      lcd_vsync_o <= ~SYNC_POL;
      underflow_o <= 1'b0;
    end else begin
      fs_q        <= h_wrap && v_wrap;
      de1         <= pix_req_o;
      hs1         <= h_ph == PH_SYNC;
      vs1         <= v_ph == PH_SYNC;
      lcd_de_o    <= de1;
      rgb_q       <= de1 && pix_valid_i ? pix_data_i : 16'h0000;
      lcd_hsync_o <= hs1 ? SYNC_POL : ~SYNC_POL;
      lcd_vsync_o <= vs1 ? SYNC_POL : ~SYNC_POL;
      underflow_o <= underflow_o || (de1 && !pix_valid_i);
    end
  assign {lcd_r_o, lcd_g_o, lcd_b_o} = rgb_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: randomized raster/pipeline check of lcd_timing_gen against a position-based model
module tb_lcd_timing_gen;
  localparam int HS = 3, HB = 4, HA = 10, HF = 2;
  localparam int VS = 2, VB = 3, VA = 6, VF = 2;
  localparam int CW = 10;
  localparam bit POL = 1'b0;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_req_o, frame_start_o, lcd_de_o, lcd_hsync_o, lcd_vsync_o, underflow_o;
  logic [CW-1:0] x_o, y_o;
  logic [15:0]   pix_data_i = '0;
  logic          pix_valid_i = 1'b0;
  logic [4:0]    lcd_r_o, lcd_b_o;
  logic [5:0]    lcd_g_o;
  int            n_cmp = 0, n_bad = 0;
  int            n, req_cnt, last_fs, drop_n;
  bit            exp_uf;
  logic [15:0]   data_h[4096];
  bit            valid_h[4096];
  lcd_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .SYNC_POL(POL), .CW(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pix_req_o(pix_req_o), .x_o(x_o), .y_o(y_o),
    .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .frame_start_o(frame_start_o),
    .lcd_de_o(lcd_de_o), .lcd_hsync_o(lcd_hsync_o), .lcd_vsync_o(lcd_vsync_o),
    .lcd_r_o(lcd_r_o), .lcd_g_o(lcd_g_o), .lcd_b_o(lcd_b_o), .underflow_o(underflow_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask
  function automatic int hpos(input int k);
    return k % HT;
  endfunction
  function automatic int vpos(input int k);
    return (k / HT) % VT;
  endfunction
  function automatic bit active(input int k);
    if (k < 0) return 1'b0;
    return hpos(k) >= HS + HB && hpos(k) < HS + HB + HA && vpos(k) >= VS + VB && vpos(k) < VS + VB + VA;
  endfunction
  task automatic check_cycle();
    bit a, de, hs, vs;
    logic [15:0] rgb;
    a = active(n);
    check("pix_req", pix_req_o, a);
    check("x", x_o, a ? hpos(n) - (HS + HB) : 0);
    check("y", y_o, a ? vpos(n) - (VS + VB) : 0);
    check("frame_start", frame_start_o, n % FT == 0);
    if (frame_start_o) begin
      if (last_fs >= 0) check("frame_period", n - last_fs, FT);
      last_fs = n;
    end
    if (a) req_cnt++;
    if (n % FT == FT - 1) begin
      check("reqs_per_frame", req_cnt, HA * VA);
      req_cnt = 0;
    end
    de = 0; hs = 0; vs = 0; rgb = '0;
    if (n >= 2) begin
      de  = active(n - 2);
      hs  = hpos(n - 2) < HS;
      vs  = vpos(n - 2) < VS;
      rgb = de && valid_h[n-1] ? data_h[n-1] : 16'h0000;
      if (de && !valid_h[n-1]) exp_uf = 1'b1;
    end
    check("de", lcd_de_o, de);
    check("hsync", lcd_hsync_o, hs ? POL : !POL);
    check("vsync", lcd_vsync_o, vs ? POL : !POL);
    check("rgb", {lcd_r_o, lcd_g_o, lcd_b_o}, rgb);
    check("underflow", underflow_o, exp_uf);
  endtask
  task automatic run(input int cycles, input int drop_rate);
    for (int i = 0; i < cycles; i++) begin
      check_cycle();
      pix_valid_i = n == drop_n ? 1'b0 : drop_rate == 0 ? 1'b1 : $urandom_range(drop_rate - 1) != 0;
      pix_data_i  = 16'($urandom);
      valid_h[n]  = pix_valid_i;
      data_h[n]   = pix_data_i;
      @(posedge clk);
      @(negedge clk);
      #1;
      n++;
    end
  endtask
  task automatic check_reset_state();
    check("rst_pix_req", pix_req_o, 0);
    check("rst_x", x_o, 0);
    check("rst_y", y_o, 0);
    check("rst_frame_start", frame_start_o, 0);
    check("rst_de", lcd_de_o, 0);
    check("rst_hsync", lcd_hsync_o, !POL);
    check("rst_vsync", lcd_vsync_o, !POL);
    check("rst_rgb", {lcd_r_o, lcd_g_o, lcd_b_o}, 0);
    check("rst_underflow", underflow_o, 0);
  endtask
  task automatic release_reset();
    rst = 1'b0;
    #1;
    n = 0; req_cnt = 0; last_fs = -1; exp_uf = 1'b0;
  endtask
  initial begin
    drop_n = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n = -1;
    check_reset_state();
    release_reset();
    run(FT, 0);
    drop_n = FT + (VS + VB + 2) * HT + HS + HB + 3 + 1;
    run(FT + (VS + VB + 3) * HT + HS + HB + 5, 0);
    drop_n = -1;
    check("mid_active_before_reset", pix_req_o, 1);
    rst = 1'b1;
    #1;
    check("rst_comb_pix_req", pix_req_o, 0);
    check("rst_comb_frame_start", frame_start_o, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state();
    release_reset();
    run(2 * FT + 20, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
